// File: rtl/mock_array_edge.sv
// Stream-to-array edge adapter: injects words into the first Element, recaptures them
// at the far edge after DEPTH hops, and returns them through a credit-guarded FIFO.
`timescale 1ns/1ps
module mock_array_edge #(
   parameter int WIDTH      = 64,
   parameter int DEPTH      = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clock,
   input  logic                          reset_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [WIDTH-1:0]              in_data,
   output logic [WIDTH-1:0]              array_out,
   input  logic [WIDTH-1:0]              array_in,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [WIDTH-1:0]              out_data,
   output logic [$clog2(DEPTH+2)-1:0]    inflight,
   output logic [15:0]                   tx_count,
   output logic [15:0]                   rx_count
);

   localparam int IW = $clog2(DEPTH + 2);
   localparam int FW = $clog2(FIFO_DEPTH + 1);
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   logic [WIDTH-1:0] array_out_q, array_out_d;
   logic [DEPTH:0]   vld_q, vld_d;
   logic [IW-1:0]    inflight_q, inflight_d;
   logic [FW-1:0]    fifo_count_q, fifo_count_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [WIDTH-1:0] mem_d [FIFO_DEPTH];
   logic [15:0]      tx_count_q, tx_count_d;
   logic [15:0]      rx_count_q, rx_count_d;

   logic accept;
   logic capture;
   logic pop;

   // Credits cover both words still travelling through the array and words already
   // buffered, so a capture always finds a free FIFO slot.
   assign in_ready  = (int'(inflight_q) + int'(fifo_count_q)) < FIFO_DEPTH;
   assign accept    = in_valid & in_ready;
   assign capture   = vld_q[DEPTH];
   assign out_valid = (fifo_count_q != '0);
   assign pop       = out_valid & out_ready;

   assign array_out = array_out_q;
   assign out_data  = mem_q[rd_ptr_q];
   assign inflight  = inflight_q;
   assign tx_count  = tx_count_q;
   assign rx_count  = rx_count_q;

   always_comb begin
      array_out_d  = accept ? in_data : '0;
      vld_d        = {vld_q[DEPTH-1:0], accept};
      inflight_d   = inflight_q;
      fifo_count_d = fifo_count_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      mem_d        = mem_q;
      tx_count_d   = tx_count_q;
      rx_count_d   = rx_count_q;

      case ({accept, capture})
         2'b10:   inflight_d = inflight_q + IW'(1);
         2'b01:   inflight_d = inflight_q - IW'(1);
         default: inflight_d = inflight_q;
      endcase

      if (accept) begin
         tx_count_d = tx_count_q + 16'd1;
      end

      if (capture) begin
         mem_d[wr_ptr_q] = array_in;
         wr_ptr_d        = (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
         rx_count_d      = rx_count_q + 16'd1;
      end

      if (pop) begin
         rd_ptr_d = (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
      end

      if (capture && !pop) begin
         fifo_count_d = fifo_count_q + FW'(1);
      end else if (pop && !capture) begin
         fifo_count_d = fifo_count_q - FW'(1);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         array_out_q  <= '0;
         vld_q        <= '0;
         inflight_q   <= '0;
         fifo_count_q <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         tx_count_q   <= '0;
         rx_count_q   <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         array_out_q  <= array_out_d;
         vld_q        <= vld_d;
         inflight_q   <= inflight_d;
         fifo_count_q <= fifo_count_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         tx_count_q   <= tx_count_d;
         rx_count_q   <= rx_count_d;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

endmodule

// File: tb/tb_mock_array_edge.sv
// Bench for mock_array_edge: a 2-register behavioural array pipe, a scoreboard of accepted
// words, a per-cycle credit model, and one task per scenario.
`timescale 1ns/1ps
module tb_mock_array_edge;

   localparam int W  = 64;
   localparam int D  = 2;
   localparam int FD = 4;
   localparam int WRAP_WORDS = 65537;

   logic          clock = 1'b0;
   logic          reset_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_data;
   logic [W-1:0]  array_out;
   logic [W-1:0]  array_in;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_data;
   logic [1:0]    inflight;
   logic [15:0]   tx_count;
   logic [15:0]   rx_count;

   // second instance with a deeper FIFO so the wrap run streams at full rate
   logic          w_in_valid;
   logic          w_in_ready;
   logic [W-1:0]  w_in_data;
   logic [W-1:0]  w_array_out;
   logic [W-1:0]  w_array_in;
   logic          w_out_valid;
   logic          w_out_ready;
   logic [W-1:0]  w_out_data;
   logic [1:0]    w_inflight;
   logic [15:0]   w_tx_count;
   logic [15:0]   w_rx_count;

   logic [W-1:0]  p1 = '0, p2 = '0;
   logic [W-1:0]  wp1 = '0, wp2 = '0;

   int            checks = 0;
   int            errors = 0;
   bit            verbose = 1'b1;
   logic [W-1:0]  sb_q[$];
   bit [D:0]      m_vld;
   int            m_fcnt;
   bit            prev_simul;
   int            prev_inf;
   int            simul_count;

   always #5 clock = ~clock;

   mock_array_edge #(.WIDTH(W), .DEPTH(D), .FIFO_DEPTH(FD)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .array_out (array_out),
      .array_in  (array_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .inflight  (inflight),
      .tx_count  (tx_count),
      .rx_count  (rx_count)
   );

   mock_array_edge #(.WIDTH(W), .DEPTH(D), .FIFO_DEPTH(8)) u_wrap (
      .clock     (clock),
      .reset_n   (reset_n),
      .in_valid  (w_in_valid),
      .in_ready  (w_in_ready),
      .in_data   (w_in_data),
      .array_out (w_array_out),
      .array_in  (w_array_in),
      .out_valid (w_out_valid),
      .out_ready (w_out_ready),
      .out_data  (w_out_data),
      .inflight  (w_inflight),
      .tx_count  (w_tx_count),
      .rx_count  (w_rx_count)
   );

   // Behavioural stand-in for two Element register hops; deliberately not reset.
   always @(posedge clock) begin
      p1  <= array_out;
      p2  <= p1;
      wp1 <= w_array_out;
      wp2 <= wp1;
   end
   assign array_in   = p2;
   assign w_array_in = wp2;

   // Scoreboard and credit model, sampled mid-cycle while inputs are stable.
   always @(negedge clock) begin : mon
      bit           acc;
      bit           cap;
      bit           pop;
      bit           exp_rdy;
      int           m_inf;
      logic [W-1:0] exp;
      if (!reset_n) begin
         sb_q.delete();
         m_vld      = '0;
         m_fcnt     = 0;
         prev_simul = 1'b0;
      end else begin
         m_inf   = $countones(m_vld);
         exp_rdy = (m_inf + m_fcnt) < FD;
         checks++;
         if (in_ready !== exp_rdy) begin
            errors++;
            $display("FAIL in_ready_credit t=%0t got=%b exp=%b", $time, in_ready, exp_rdy);
         end
         checks++;
         if (inflight !== 2'(m_inf)) begin
            errors++;
            $display("FAIL inflight t=%0t got=%0d exp=%0d", $time, inflight, m_inf);
         end
         checks++;
         if (out_valid !== (m_fcnt != 0)) begin
            errors++;
            $display("FAIL out_valid t=%0t got=%b exp=%b", $time, out_valid, (m_fcnt != 0));
         end
         if (prev_simul) begin
            checks++;
            if (inflight !== 2'(prev_inf) || out_valid !== 1'b1) begin
               errors++;
               $display("FAIL steady_state t=%0t inflight=%0d exp=%0d out_valid=%b exp=1",
                        $time, inflight, prev_inf, out_valid);
            end
         end
         acc = in_valid && in_ready;
         cap = m_vld[D];
         pop = out_valid && out_ready;
         if (acc) begin
            sb_q.push_back(in_data);
            if (verbose) $display("tx  data=%h", in_data);
         end
         if (pop) begin
            checks++;
            if (sb_q.size() == 0) begin
               errors++;
               $display("FAIL pop_empty t=%0t got=%h exp=<none>", $time, out_data);
            end else begin
               exp = sb_q.pop_front();
               if (out_data !== exp) begin
                  errors++;
                  $display("FAIL out_data t=%0t got=%h exp=%h", $time, out_data, exp);
               end else if (verbose) begin
                  $display("rx  data=%h", out_data);
               end
            end
         end
         checks++;
         if (cap && !pop && m_fcnt >= FD) begin
            errors++;
            $display("FAIL fifo_overflow t=%0t count=%0d exp<%0d", $time, m_fcnt, FD);
         end
         prev_simul = acc && cap && pop;
         prev_inf   = m_inf;
         if (prev_simul) simul_count++;
         m_fcnt = m_fcnt + int'(cap) - int'(pop);
         m_vld  = {m_vld[D-1:0], acc};
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      in_valid   = 1'b0;
      in_data    = '0;
      out_ready  = 1'b0;
      w_in_valid = 1'b0;
      w_in_data  = '0;
      reset_n    = 1'b0;
      repeat (3) @(posedge clock);
      #1 reset_n = 1'b1;
   endtask

   // Offers w until accepted; returns the number of cycles spent waiting.
   task automatic send_word(input logic [W-1:0] w, output int waits, output bit ok);
      bit acc;
      ok       = 1'b0;
      waits    = 0;
      in_valid = 1'b1;
      in_data  = w;
      for (int i = 0; i < 50; i++) begin
         @(negedge clock);
         acc = in_ready;
         tick();
         if (acc) begin
            ok = 1'b1;
            break;
         end
         waits++;
      end
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while ((sb_q.size() != 0 || out_valid !== 1'b0) && n < 100) begin
         tick();
         n++;
      end
      checks++;
      if (n >= 100) begin
         errors++;
         $display("FAIL %s_drain pending=%0d exp=0", name, sb_q.size());
      end
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      checks++;
      if (in_ready !== 1'b1)   begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      checks++;
      if (out_valid !== 1'b0)  begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++;
      if (out_data !== '0)     begin errors++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
      checks++;
      if (array_out !== '0)    begin errors++; $display("FAIL reset_array_out got=%h exp=0", array_out); end
      checks++;
      if (inflight !== 2'd0)   begin errors++; $display("FAIL reset_inflight got=%0d exp=0", inflight); end
      checks++;
      if (tx_count !== 16'd0 || rx_count !== 16'd0) begin
         errors++;
         $display("FAIL reset_counts tx=%0d rx=%0d exp=0/0", tx_count, rx_count);
      end
   endtask

   task automatic test_single();
      logic [W-1:0] w;
      int           waits;
      bit           ok;
      w = 64'hDEAD_BEEF_0000_0001;
      do_reset();
      out_ready = 1'b1;
      send_word(w, waits, ok);
      in_valid = 1'b0;
      checks++;
      if (!ok || array_out !== w) begin
         errors++;
         $display("FAIL single_array_out got=%h exp=%h", array_out, w);
      end
      tick();
      tick();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got=%b exp=0", out_valid); end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== w) begin
         errors++;
         $display("FAIL single_output valid=%b data=%h exp=1/%h", out_valid, out_data, w);
      end
      tick();
      tick();
      checks++;
      if (tx_count !== 16'd1 || rx_count !== 16'd1 || inflight !== 2'd0) begin
         errors++;
         $display("FAIL single_counts tx=%0d rx=%0d inflight=%0d exp=1/1/0", tx_count, rx_count, inflight);
      end
   endtask

   task automatic test_streaming();
      int waits;
      bit ok;
      bit saw_stall;
      do_reset();
      out_ready = 1'b1;
      saw_stall = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         send_word(W'(i), waits, ok);
         if (waits > 0) saw_stall = 1'b1;
         checks++;
         if (!ok) begin errors++; $display("FAIL stream_accept word=%0d got=timeout exp=accepted", i); end
      end
      in_valid = 1'b0;
      drain("stream");
      checks++;
      if (saw_stall !== 1'b1) begin errors++; $display("FAIL stream_stall got=%b exp=1", saw_stall); end
      checks++;
      if (tx_count !== 16'd8 || rx_count !== 16'd8) begin
         errors++;
         $display("FAIL stream_counts tx=%0d rx=%0d exp=8/8", tx_count, rx_count);
      end
   endtask

   task automatic test_backpressure();
      int n;
      bit acc;
      do_reset();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      n = 0;
      for (int c = 0; c < 20; c++) begin
         in_data = W'(n + 1);
         @(negedge clock);
         acc = in_ready;
         tick();
         if (acc) n++;
      end
      checks++;
      if (n !== 4) begin errors++; $display("FAIL bp_accepted got=%0d exp=4", n); end
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
      out_ready = 1'b1;
      for (int c = 0; c < 40 && n < 6; c++) begin
         in_data = W'(n + 1);
         @(negedge clock);
         acc = in_ready;
         tick();
         if (acc) n++;
      end
      in_valid = 1'b0;
      checks++;
      if (n !== 6) begin errors++; $display("FAIL bp_total got=%0d exp=6", n); end
      drain("bp");
      checks++;
      if (tx_count !== 16'd6 || rx_count !== 16'd6) begin
         errors++;
         $display("FAIL bp_counts tx=%0d rx=%0d exp=6/6", tx_count, rx_count);
      end
   endtask

   task automatic test_back_to_back();
      int waits;
      bit ok;
      do_reset();
      out_ready   = 1'b1;
      simul_count = 0;
      for (int i = 0; i < 16; i++) begin
         send_word(64'hB2B0_0000_0000_0000 | W'(i), waits, ok);
         checks++;
         if (!ok) begin errors++; $display("FAIL b2b_accept word=%0d got=timeout exp=accepted", i); end
      end
      in_valid = 1'b0;
      drain("b2b");
      checks++;
      if (simul_count == 0) begin errors++; $display("FAIL b2b_simul got=%0d exp>0", simul_count); end
      checks++;
      if (tx_count !== 16'd16 || rx_count !== 16'd16) begin
         errors++;
         $display("FAIL b2b_counts tx=%0d rx=%0d exp=16/16", tx_count, rx_count);
      end
   endtask

   task automatic test_reset_midop();
      int waits;
      bit ok;
      do_reset();
      out_ready = 1'b0;
      send_word(64'hAAAA_0000_0000_0001, waits, ok);
      in_valid = 1'b0;
      tick();
      send_word(64'hBBBB_0000_0000_0002, waits, ok);
      send_word(64'hCCCC_0000_0000_0003, waits, ok);
      in_valid = 1'b0;
      checks++;
      if (inflight !== 2'd2 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL midop_setup inflight=%0d out_valid=%b exp=2/1", inflight, out_valid);
      end
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || array_out !== '0) begin
         errors++;
         $display("FAIL midop_reset out_valid=%b array_out=%h exp=0/0", out_valid, array_out);
      end
      checks++;
      if (tx_count !== 16'd0 || rx_count !== 16'd0) begin
         errors++;
         $display("FAIL midop_counts tx=%0d rx=%0d exp=0/0", tx_count, rx_count);
      end
      @(posedge clock);
      #1 reset_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         tick();
         checks++;
         if (out_valid !== 1'b0) begin errors++; $display("FAIL midop_stale cycle=%0d got=%b exp=0", c, out_valid); end
      end
      checks++;
      if (rx_count !== 16'd0) begin errors++; $display("FAIL midop_rx got=%0d exp=0", rx_count); end
   endtask

   task automatic test_counter_wrap();
      logic [W-1:0] wq[$];
      logic [W-1:0] exp;
      int           sent;
      int           got;
      int           bad;
      bit           acc;
      do_reset();
      verbose     = 1'b0;
      w_out_ready = 1'b1;
      w_in_valid  = 1'b1;
      sent = 0;
      got  = 0;
      bad  = 0;
      for (int c = 0; c < 70000 && got < WRAP_WORDS; c++) begin
         w_in_data = {32'h5A5A_0000, 32'(sent)};
         @(negedge clock);
         acc = w_in_valid && w_in_ready;
         if (acc) begin
            wq.push_back(w_in_data);
            sent++;
         end
         if (w_out_valid === 1'b1) begin
            if (wq.size() == 0) begin
               bad++;
            end else begin
               exp = wq.pop_front();
               if (w_out_data !== exp) bad++;
            end
            got++;
         end
         tick();
         if (sent >= WRAP_WORDS) w_in_valid = 1'b0;
      end
      w_in_valid = 1'b0;
      tick();
      $display("wrap sent=%0d received=%0d", sent, got);
      checks++;
      if (got !== WRAP_WORDS) begin errors++; $display("FAIL wrap_received got=%0d exp=%0d", got, WRAP_WORDS); end
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL wrap_order got=%0d bad words exp=0", bad); end
      checks++;
      if (w_tx_count !== 16'd1 || w_rx_count !== 16'd1) begin
         errors++;
         $display("FAIL wrap_counts tx=%0d rx=%0d exp=1/1", w_tx_count, w_rx_count);
      end
      verbose = 1'b1;
   endtask

   initial begin
      w_out_ready = 1'b1;
      test_reset();
      test_single();
      test_streaming();
      test_backpressure();
      test_back_to_back();
      test_reset_midop();
      test_counter_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog t=%0t exp=finish", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
